lfsr_prbs_engine: RTL
=====================

# lfsr_prbs_engine

Parametrised PRBS generator and checker built around a Fibonacci LFSR. Width, feedback polynomial and bits advanced per clock are parameters, so one block covers every pattern length and datapath width. In generate mode it produces a seeded pseudo-random stream. In check mode it self-synchronises to a received stream, declares lock and counts bit errors. It sits beside the datapath, driving test patterns out or checking them on the way back in.

## Interface
- Width, 16, LFSR length, 2..32
- Taps, 16'hB400, feedback mask; bit i set means state[i] feeds the XOR (default is maximal-length x^16+x^14+x^13+x^11+1)
- Bits_Per_Clock, 1, LFSR steps per enabled cycle, 1..Width
- Err_Cnt_Width, 16, error counter width
- Lock_Count, 8, consecutive clean steps in VERIFY before lock is declared
- Lose_Count, 4, consecutive errored steps in LOCKED before lock is dropped

Ports (one clock; reset is asynchronous and active-low):
- Clock  in  1  rising-edge clock
- ares_L  in  1  asynchronous active-low reset
- mode  in  1  0 = generate, 1 = check
- ld_en  in  1  load Seed_Data_In into the state; has priority over shift_en
- Seed_Data_In  in  Width  seed value
- shift_en  in  1  advance Bits_Per_Clock steps
- Rx_Data_In  in  Bits_Per_Clock  received bits, bit [B-1] oldest; used only in check mode
- clr_err  in  1  synchronous clear of Err_Count
- PRBS_Data_Out  out  Bits_Per_Clock  bits shifted out, bit [B-1] first
- State_Out  out  Width  current LFSR state
- locked  out  1  checker in LOCKED
- err_flag  out  1  one-cycle pulse for an errored step
- Err_Count  out  Err_Cnt_Width  saturating count of errored bits

## Operation
- Single step:
  - fb = ^(s & Taps); if s == 0 then fb = 1 (auto-start).
  - Shifted-out bit = s[Width-1].
  - s' = {s[Width-2:0], fb}.
- B steps are chained combinationally within one cycle; the all-zero check applies at every sub-step.
- Generate mode:
  - ld_en: s <= Seed. A zero seed is legal.
  - shift_en: s advances B steps and PRBS_Data_Out <= the shifted-out bits.
  - locked = 0; error logic idle.
- Check mode FSM:
  - HUNT (reset state):
    - On shift_en: s <= {s, Rx_Data_In} truncated to Width, and fill += B.
    - When fill >= Width, go to VERIFY.
  - VERIFY:
    - On shift_en: predict B bits from s and compare with Rx_Data_In.
    - Match: s advances, good += 1. When good reaches Lock_Count, go to LOCKED.
    - Any mismatch: go to HUNT, s <= {s, Rx}, fill = B, good = 0.
  - LOCKED:
    - On shift_en: compare prediction with Rx. s always advances by prediction, so received errors do not propagate.
    - Mismatch: err_flag = 1, Err_Count += popcount(mismatch), saturating at all-ones, bad += 1.
    - Clean step: bad = 0.
    - When bad reaches Lose_Count, go to HUNT with fill = 0.
- ld_en in check mode: s <= Seed, FSM goes to VERIFY, good = 0.
- Any change of mode: FSM goes to HUNT; fill, good and bad are cleared; s holds; Err_Count holds.
- clr_err: Err_Count <= 0. It wins over a same-cycle increment.
- Err_Count increments only in LOCKED.

## Timing
- All outputs are registered.
- Reset values: s = 0, PRBS_Data_Out = 0, locked = 0, err_flag = 0, Err_Count = 0, FSM = HUNT, all internal counters = 0.
- Reset mid-operation takes effect immediately, without waiting for Clock.
- Latency: one cycle from shift_en or ld_en to State_Out, PRBS_Data_Out and err_flag.
- locked rises in the cycle after the Lock_Count-th clean step, and falls in the cycle after the Lose_Count-th errored step.
- With shift_en low, every register holds except those changed by ld_en, clr_err or a mode change.

## Test plan
- Reset: drive ares_L low mid-stream with Clock stopped -> all outputs 0 and State_Out = 0x0000 at once.
- Width=16, B=1, load 0xACE1, one shift -> State_Out = 0x59C3, PRBS_Data_Out = 1.
- Load 0x0000, one shift -> State_Out = 0x0001. Free-run from there -> State_Out returns to 0x0001 after exactly 65535 shifts and not earlier.
- B=8: load 0xACE1, one shift -> State_Out and the 8 output bits equal 8 single-step shifts of a B=1 instance.
- Loopback generator -> checker, continuous shift_en, B=1:
  - locked rises after 16 + 8 steps.
  - One flipped bit -> err_flag for one cycle, Err_Count = 1, locked stays 1.
  - 4 consecutive flipped bits -> locked falls, then relocks after 24 further clean steps.
- Err_Count with Err_Cnt_Width=4:
  - Force 20 errors -> count holds at 15.
  - clr_err coincident with an error -> count = 0.
  - Mode toggle -> locked = 0 and FSM = HUNT.

Source files
------------

// File: rtl/lfsr_prbs_engine.sv
// Fibonacci-LFSR PRBS generator / self-synchronising checker.
// Generate mode emits a seeded pattern; check mode hunts for alignment on the
// received stream, verifies it, declares lock and counts errored bits.
module lfsr_prbs_engine #(
  parameter int unsigned Width          = 16,
  parameter logic [31:0] Taps           = 32'h0000_B400,
  parameter int unsigned Bits_Per_Clock = 1,
  parameter int unsigned Err_Cnt_Width  = 16,
  parameter int unsigned Lock_Count     = 8,
  parameter int unsigned Lose_Count     = 4
) (
  input  logic                      Clock,
  input  logic                      ares_L,
  input  logic                      mode,
  input  logic                      ld_en,
  input  logic [Width-1:0]          Seed_Data_In,
  input  logic                      shift_en,
  input  logic [Bits_Per_Clock-1:0] Rx_Data_In,
  input  logic                      clr_err,
  output logic [Bits_Per_Clock-1:0] PRBS_Data_Out,
  output logic [Width-1:0]          State_Out,
  output logic                      locked,
  output logic                      err_flag,
  output logic [Err_Cnt_Width-1:0]  Err_Count
);

  localparam logic [Width-1:0] TapMask = Taps[Width-1:0];
  localparam int unsigned FW = $clog2(Width + Bits_Per_Clock + 1);
  localparam int unsigned GW = $clog2(Lock_Count + 1);
  localparam int unsigned BW = $clog2(Lose_Count + 1);
  localparam int unsigned SW = Err_Cnt_Width + 7;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} chk_state_e;

  chk_state_e               state_q;
  logic [Width-1:0]         s_q;
  logic [Bits_Per_Clock-1:0] prbs_q;
  logic                     locked_q;
  logic                     err_flag_q;
  logic [Err_Cnt_Width-1:0] err_cnt_q;
  logic                     mode_q;
  logic [FW-1:0]            fill_q;
  logic [GW-1:0]            good_q;
  logic [BW-1:0]            bad_q;

  logic [Width-1:0]          chain_s;
  logic                      fb_bit;
  logic [Bits_Per_Clock-1:0] sh_acc;
  logic [Bits_Per_Clock-1:0] fb_acc;
  logic [Width-1:0]          adv_s;
  logic [Width-1:0]          hunt_s;
  logic [Bits_Per_Clock-1:0] mismatch;
  logic [6:0]                pop_cnt;
  logic [SW-1:0]             cnt_sum;
  logic [Err_Cnt_Width-1:0]  cnt_inc;
  logic [FW-1:0]             fill_sum;
  logic                      mode_chg;

  // Chain B single steps; each sub-step applies the all-zero auto-start.
  // The feedback bits double as the checker's prediction of the next B
  // received bits, since a matched step appends exactly those bits to s.
  always_comb begin
    chain_s = s_q;
    fb_bit  = 1'b0;
    sh_acc  = '0;
    fb_acc  = '0;
    for (int unsigned k = 0; k < Bits_Per_Clock; k++) begin
      fb_bit  = (chain_s == '0) ? 1'b1 : ^(chain_s & TapMask);
      sh_acc  = (sh_acc << 1) | Bits_Per_Clock'(chain_s[Width-1]);
      fb_acc  = (fb_acc << 1) | Bits_Per_Clock'(fb_bit);
      chain_s = {chain_s[Width-2:0], fb_bit};
    end
    adv_s = chain_s;
  end

  generate
    if (Bits_Per_Clock >= Width) begin : g_hunt_full
      // Received word replaces the whole state.
      always_comb hunt_s = Rx_Data_In[Width-1:0];
    end else begin : g_hunt_part
      // Received bits are appended below the surviving state bits.
      always_comb hunt_s = {s_q[Width-1-Bits_Per_Clock:0], Rx_Data_In};
    end
  endgenerate

  // Error accounting and counter arithmetic for the FSM.
  always_comb begin
    mismatch = fb_acc ^ Rx_Data_In;
    pop_cnt  = 7'($countones(mismatch));
    cnt_sum  = SW'(err_cnt_q) + SW'(pop_cnt);
    cnt_inc  = (cnt_sum > SW'({Err_Cnt_Width{1'b1}})) ? '1 : cnt_sum[Err_Cnt_Width-1:0];
    fill_sum = fill_q + FW'(Bits_Per_Clock);
    mode_chg = mode ^ mode_q;
  end

  // LFSR state, checker FSM and all registered outputs.
  always_ff @(posedge Clock or negedge ares_L) begin
    if (!ares_L) begin
      state_q    <= HUNT;
      s_q        <= '0;
      prbs_q     <= '0;
      locked_q   <= 1'b0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
      mode_q     <= 1'b0;
      fill_q     <= '0;
      good_q     <= '0;
      bad_q      <= '0;
    end else begin
      err_flag_q <= 1'b0;
      mode_q     <= mode;
      if (mode_chg) begin
        state_q  <= HUNT;
        fill_q   <= '0;
        good_q   <= '0;
        bad_q    <= '0;
        locked_q <= 1'b0;
      end else if (ld_en) begin
        s_q      <= Seed_Data_In;
        fill_q   <= '0;
        good_q   <= '0;
        bad_q    <= '0;
        locked_q <= 1'b0;
        state_q  <= mode ? VERIFY : HUNT;
      end else if (shift_en) begin
        prbs_q <= sh_acc;
        if (!mode) begin
          s_q <= adv_s;
        end else begin
          case (state_q)
            HUNT: begin
              s_q <= hunt_s;
              if (fill_sum >= FW'(Width)) begin
                state_q <= VERIFY;
                fill_q  <= '0;
                good_q  <= '0;
              end else begin
                fill_q <= fill_sum;
              end
            end
            VERIFY: begin
              if (mismatch == '0) begin
                s_q <= adv_s;
                if (good_q == GW'(Lock_Count - 1)) begin
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
                  good_q   <= '0;
                  bad_q    <= '0;
                end else begin
                  good_q <= good_q + GW'(1);
                end
              end else begin
                s_q     <= hunt_s;
                state_q <= HUNT;
                fill_q  <= FW'(Bits_Per_Clock);
                good_q  <= '0;
              end
            end
            LOCKED: begin
              s_q <= adv_s;
              if (mismatch != '0) begin
                err_flag_q <= 1'b1;
                err_cnt_q  <= cnt_inc;
                if (bad_q == BW'(Lose_Count - 1)) begin
                  state_q  <= HUNT;
                  locked_q <= 1'b0;
                  fill_q   <= '0;
                  bad_q    <= '0;
                end else begin
                  bad_q <= bad_q + BW'(1);
                end
              end else begin
                bad_q <= '0;
              end
            end
            default: state_q <= HUNT;
          endcase
        end
      end
      if (clr_err) err_cnt_q <= '0;
    end
  end

  assign PRBS_Data_Out = prbs_q;
  assign State_Out     = s_q;
  assign locked        = locked_q;
  assign err_flag      = err_flag_q;
  assign Err_Count     = err_cnt_q;

endmodule
